// File: rtl/logic_gate_tester.sv
// Self-checking stimulus/response block for a six-gate unit (OR, AND, NAND, XOR, NOT, NOR).
// Optional macro LOGIC_GATE_TESTER_STOP_ON_FAIL_EN ends the run at the first failing vector.
module logic_gate_tester #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    output logic       c,
    input  logic       yor,
    input  logic       yand,
    input  logic       ynand,
    input  logic       yxor,
    input  logic       ynot,
    input  logic       ynor,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [2:0] fail_vec,
    output logic [5:0] fail_mask
);

    localparam int SETTLE_EFF = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
    localparam int CW         = (SETTLE_EFF < 2) ? 1 : $clog2(SETTLE_EFF);
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_EFF - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Reference gate responses, bit order {or, and, nand, xor, not, nor}
    function automatic logic [5:0] gate_expect(input logic ia, input logic ib, input logic ic);
        return {ia | ib, ia & ib, ~(ia & ib), ia ^ ib, ~ic, ~(ia | ib)};
    endfunction

    state_t        state_r, state_s;
    logic [2:0]    vec_r, vec_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic [2:0]    abc_r, abc_s;
    logic          busy_r, busy_s;
    logic          done_r, done_s;
    logic          pass_r, pass_s;
    logic [3:0]    err_r, err_s;
    logic [2:0]    fvec_r, fvec_s;
    logic [5:0]    fmask_r, fmask_s;
    logic [5:0]    mismatch_s;
    logic          last_s;

    // Compare against values derived from the registered stimulus, not the gate inputs
    assign mismatch_s = gate_expect(abc_r[2], abc_r[1], abc_r[0])
                      ^ {yor, yand, ynand, yxor, ynot, ynor};

    // Next-state and next-output logic
    always_comb begin
        state_s = state_r;
        vec_s   = vec_r;
        cnt_s   = cnt_r;
        abc_s   = abc_r;
        busy_s  = busy_r;
        done_s  = done_r;
        pass_s  = pass_r;
        err_s   = err_r;
        fvec_s  = fvec_r;
        fmask_s = fmask_r;
        last_s  = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    state_s = SETTLE;
                    vec_s   = 3'd0;
                    cnt_s   = CW'(0);
                    abc_s   = 3'd0;
                    busy_s  = 1'b1;
                    done_s  = 1'b0;
                    pass_s  = 1'b0;
                    err_s   = 4'd0;
                    fvec_s  = 3'd0;
                    fmask_s = 6'd0;
                end else if (state_r == IDLE) begin
                    pass_s  = 1'b0;
                    err_s   = 4'd0;
                    fvec_s  = 3'd0;
                    fmask_s = 6'd0;
                end else begin
                    done_s  = 1'b1;
                end
            end
            SETTLE: begin
                abc_s = vec_r;
                if (cnt_r == CNT_LAST) begin
                    state_s = CHECK;
                    cnt_s   = CW'(0);
                end else begin
                    cnt_s   = cnt_r + CW'(1);
                end
            end
            CHECK: begin
                if (|mismatch_s) begin
                    err_s = err_r + 4'd1;
                    if (err_r == 4'd0) begin
                        fvec_s  = vec_r;
                        fmask_s = mismatch_s;
                    end else begin
                        fvec_s  = fvec_r;
                    end
                end else begin
                    err_s = err_r;
                end
`ifdef LOGIC_GATE_TESTER_STOP_ON_FAIL_EN
                last_s = (vec_r == 3'd7) || (|mismatch_s);
`else
                last_s = (vec_r == 3'd7);
`endif
                if (last_s) begin
                    state_s = DONE;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                    pass_s  = (err_s == 4'd0);
                    abc_s   = 3'd0;
                end else begin
                    state_s = SETTLE;
                    vec_s   = vec_r + 3'd1;
                    cnt_s   = CW'(0);
                    abc_s   = vec_r + 3'd1;
                end
            end
            default: begin
                state_s = IDLE;
                vec_s   = 3'd0;
                cnt_s   = CW'(0);
                abc_s   = 3'd0;
                busy_s  = 1'b0;
                done_s  = 1'b0;
                pass_s  = 1'b0;
                err_s   = 4'd0;
                fvec_s  = 3'd0;
                fmask_s = 6'd0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            vec_r   <= 3'd0;
            cnt_r   <= CW'(0);
            abc_r   <= 3'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            pass_r  <= 1'b0;
            err_r   <= 4'd0;
            fvec_r  <= 3'd0;
            fmask_r <= 6'd0;
        end else begin
            state_r <= state_s;
            vec_r   <= vec_s;
            cnt_r   <= cnt_s;
            abc_r   <= abc_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            pass_r  <= pass_s;
            err_r   <= err_s;
            fvec_r  <= fvec_s;
            fmask_r <= fmask_s;
        end
    end

    assign a         = abc_r[2];
    assign b         = abc_r[1];
    assign c         = abc_r[0];
    assign busy      = busy_r;
    assign done      = done_r;
    assign pass      = pass_r;
    assign err_count = err_r;
    assign fail_vec  = fvec_r;
    assign fail_mask = fmask_r;

endmodule

// File: tb/tb_logic_gate_tester.sv
// Scoreboard bench: two testers (SETTLE_CYCLES=2 and 0) drive a behavioural gate unit
// whose per-vector fault masks are chosen by the bench; a model predicts each run's report.
module tb_logic_gate_tester;

    typedef struct {
        int err;
        int pas;
        int fv;
        int fm;
        int done_at;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    logic [5:0] flip [8];
    exp_t q2[$];
    exp_t q0[$];

    logic       a2, b2, c2, busy2, done2, pass2;
    logic [3:0] err2;
    logic [2:0] fv2;
    logic [5:0] fm2, g2;
    logic       a0, b0, c0, busy0, done0, pass0;
    logic [3:0] err0;
    logic [2:0] fv0;
    logic [5:0] fm0, g0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Healthy gate truth, bit order {or, and, nand, xor, not, nor}
    function automatic logic [5:0] gates(input logic [2:0] v);
        logic x, y, z;
        x = v[2]; y = v[1]; z = v[0];
        return {x | y, x & y, !(x & y), x ^ y, !z, !(x | y)};
    endfunction

    assign g2 = gates({a2, b2, c2}) ^ flip[{a2, b2, c2}];
    assign g0 = gates({a0, b0, c0}) ^ flip[{a0, b0, c0}];

    logic_gate_tester #(.SETTLE_CYCLES(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start), .a(a2), .b(b2), .c(c2),
        .yor(g2[5]), .yand(g2[4]), .ynand(g2[3]), .yxor(g2[2]), .ynot(g2[1]), .ynor(g2[0]),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2), .fail_vec(fv2), .fail_mask(fm2)
    );

    logic_gate_tester #(.SETTLE_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .a(a0), .b(b0), .c(c0),
        .yor(g0[5]), .yand(g0[4]), .ynand(g0[3]), .yxor(g0[2]), .ynot(g0[1]), .ynor(g0[0]),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .fail_vec(fv0), .fail_mask(fm0)
    );

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // A run's report: count of faulty vectors, first faulty vector and its fault mask
    function automatic exp_t model(input int s_eff, input int e);
        exp_t r;
        int n, first, applied;
        n = 0; first = -1; applied = 8;
        for (int v = 0; v < 8; v++) begin
            if (flip[v] != 6'd0) begin
                n++;
                if (first < 0) first = v;
            end
        end
`ifdef LOGIC_GATE_TESTER_STOP_ON_FAIL_EN
        if (first >= 0) begin
            n = 1;
            applied = first + 1;
        end
`endif
        r.err = n;
        r.pas = (n == 0) ? 1 : 0;
        r.fv = (first < 0) ? 0 : first;
        r.fm = (first < 0) ? 0 : int'(flip[first]);
        r.done_at = e + applied * (s_eff + 1);
        return r;
    endfunction

    task automatic compare_result(input string nm, input exp_t e, input logic [3:0] err,
                                  input logic pas, input logic [2:0] fv, input logic [5:0] fm,
                                  input logic [2:0] abc, input logic bsy);
        check({nm, "_done_cycle"}, cyc, e.done_at);
        check({nm, "_err_count"}, int'(err), e.err);
        check({nm, "_pass"}, int'(pas), e.pas);
        check({nm, "_fail_vec"}, int'(fv), e.fv);
        check({nm, "_fail_mask"}, int'(fm), e.fm);
        check({nm, "_abc_idle"}, int'(abc), 0);
        check({nm, "_busy_low"}, int'(bsy), 0);
    endtask

    // Monitor for the SETTLE_CYCLES=2 instance
    initial begin
        logic seen;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            if (done2 && !seen) begin
                seen = 1'b1;
                if (q2.size() == 0) check("s2_unexpected_done", 1, 0);
                else compare_result("s2", q2.pop_front(), err2, pass2, fv2, fm2, {a2, b2, c2}, busy2);
            end else if (!done2) begin
                seen = 1'b0;
            end
        end
    end

    // Monitor for the SETTLE_CYCLES=0 instance
    initial begin
        logic seen;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            if (done0 && !seen) begin
                seen = 1'b1;
                if (q0.size() == 0) check("s0_unexpected_done", 1, 0);
                else compare_result("s0", q0.pop_front(), err0, pass0, fv0, fm0, {a0, b0, c0}, busy0);
            end else if (!done0) begin
                seen = 1'b0;
            end
        end
    end

    task automatic run_start();
        int e;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        e = cyc;
        start = 1'b0;
        q2.push_back(model(2, e));
        q0.push_back(model(1, e));
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            if (q2.size() == 0 && q0.size() == 0) break;
            @(posedge clk);
        end
        if (q2.size() != 0 || q0.size() != 0) begin
            check("run_timeout", 1, 0);
            q2.delete();
            q0.delete();
        end
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, "_s2_outs"}, int'({a2, b2, c2, busy2, done2, pass2, err2, fv2, fm2}), 0);
        check({nm, "_s0_outs"}, int'({a0, b0, c0, busy0, done0, pass0, err0, fv0, fm0}), 0);
    endtask

    task automatic set_flip_zero();
        for (int v = 0; v < 8; v++) flip[v] = 6'd0;
    endtask

    initial begin
        logic [31:0] rnd;
        logic [5:0]  gv;
        set_flip_zero();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Healthy gates
        run_start();
        wait_idle();

        // NOR stuck at 0: only vectors where NOR should be 1 fail
        for (int v = 0; v < 8; v++) begin
            gv = gates(3'(v));
            flip[v] = {5'd0, gv[0]};
        end
        run_start();
        wait_idle();

        // NOT driven as c: every vector fails on the NOT bit
        for (int v = 0; v < 8; v++) flip[v] = 6'b000010;
        run_start();
        wait_idle();

        // Restart from DONE clears results; a start mid-run is ignored
        set_flip_zero();
        run_start();
        check("restart_done_low", int'(done2), 0);
        check("restart_err_cleared", int'(err2), 0);
        check("restart_busy", int'(busy2), 1);
        repeat (9) @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle();

        // Random fault patterns
        for (int r = 0; r < 6; r++) begin
            for (int v = 0; v < 8; v++) begin
                rnd = $urandom;
                flip[v] = (rnd[1:0] == 2'd0) ? rnd[7:2] : 6'd0;
            end
            run_start();
            wait_idle();
        end

        // Reset during vector 100 aborts the run in both instances
        set_flip_zero();
        flip[6] = 6'b100000;
        run_start();
        for (int i = 0; i < 100 && {a2, b2, c2} != 3'b100; i++) @(negedge clk);
        check("reach_vec4", int'({a2, b2, c2}), 4);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_all_zero("midrun_reset");
        q2.delete();
        q0.delete();
        @(negedge clk);
        rst = 1'b0;
        set_flip_zero();
        run_start();
        wait_idle();

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
